// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts a WIDTH-bit word over a valid/ready
// handshake and emits it one bit per shift_en cycle with first/last framing.
// A new word can be accepted on the edge that consumes the last bit, so
// successive words form a gapless serial stream.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              acc;
  logic              on_last;

  assign on_last = (cnt_q == CntW'(1));

  // Ready in IDLE, or while the last bit is being consumed (gapless reload).
  assign load_ready = (state_q == StIdle) | ((state_q == StShift) & on_last & shift_en);
  assign acc        = load_valid & load_ready;

  // Next-state: load on accept, shift toward the output end on shift_en.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (acc) begin
          shreg_d = data_in;
          cnt_d   = CntW'(WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        if (shift_en) begin
          if (on_last) begin
            if (acc) begin
              shreg_d = data_in;
              cnt_d   = CntW'(WIDTH);
            end else begin
              shreg_d = '0;
              cnt_d   = '0;
              state_d = StIdle;
            end
          end else begin
            if (MSB_FIRST) begin
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Serial outputs are all qualified by the SHIFT state.
  always_comb begin
    busy         = (state_q == StShift);
    serial_valid = busy;
    serial_out   = 1'b0;
    first_bit    = 1'b0;
    last_bit     = 1'b0;
    if (busy) begin
      serial_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      first_bit  = (cnt_q == CntW'(WIDTH));
      last_bit   = on_last;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first
// instance, checked cycle by cycle against hand-computed output vectors.
// Vector layout: {serial_out, serial_valid, first_bit, last_bit, busy, load_ready}.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic       shift_en;
  logic       lv1, lv2;
  logic [3:0] d1, d2;
  logic       rdy1, so1, sv1, fb1, lb1, bz1;
  logic       rdy2, so2, sv2, fb2, lb2, bz2;
  logic [5:0] obs1, obs2;

  int n_cmp = 0;
  int n_bad = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (lv1),
    .load_ready   (rdy1),
    .data_in      (d1),
    .shift_en     (shift_en),
    .serial_out   (so1),
    .serial_valid (sv1),
    .first_bit    (fb1),
    .last_bit     (lb1),
    .busy         (bz1)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (lv2),
    .load_ready   (rdy2),
    .data_in      (d2),
    .shift_en     (shift_en),
    .serial_out   (so2),
    .serial_valid (sv2),
    .first_bit    (fb2),
    .last_bit     (lb2),
    .busy         (bz2)
  );

  assign obs1 = {so1, sv1, fb1, lb1, bz1, rdy1};
  assign obs2 = {so2, sv2, fb2, lb2, bz2, rdy2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk1(input string tag, input logic [5:0] exp);
    n_cmp++;
    assert (obs1 === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs1, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [5:0] exp);
    n_cmp++;
    assert (obs2 === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs2, exp);
    end
  endtask

  initial begin
    reset = 1'b1; shift_en = 1'b1;
    lv1 = 1'b1; d1 = 4'b0110;
    lv2 = 1'b1; d2 = 4'b0110;
    tick();
    // Reset: load in the reset cycle must be dropped.
    reset = 1'b0; lv1 = 1'b0; lv2 = 1'b0; settle();
    chk1("reset_msb", 6'b000001);
    chk2("reset_lsb", 6'b000001);

    // Basic MSB-first frame 0110.
    lv1 = 1'b1; d1 = 4'b0110; settle();
    chk1("basic_idle_ready", 6'b000001);
    tick(); lv1 = 1'b0; settle();
    chk1("basic_c1", 6'b011010);
    tick(); settle(); chk1("basic_c2", 6'b110010);
    tick(); settle(); chk1("basic_c3", 6'b110010);
    tick(); settle(); chk1("basic_c4", 6'b010111);
    tick(); settle(); chk1("basic_c5_idle", 6'b000001);

    // Stall during bit 2 of 1010, and on the last bit.
    lv1 = 1'b1; d1 = 4'b1010; settle();
    tick(); lv1 = 1'b0; settle();
    chk1("stall_c1", 6'b111010);
    tick(); shift_en = 1'b0; settle(); chk1("stall_c2", 6'b010010);
    tick(); settle(); chk1("stall_c3", 6'b010010);
    tick(); shift_en = 1'b1; settle(); chk1("stall_c4", 6'b010010);
    tick(); settle(); chk1("stall_c5", 6'b110010);
    tick(); shift_en = 1'b0; settle(); chk1("stall_last_held", 6'b010110);
    shift_en = 1'b1; settle(); chk1("stall_last_go", 6'b010111);
    tick(); settle(); chk1("stall_idle", 6'b000001);

    // Back-to-back 0110 then 1001 with load_valid held.
    lv1 = 1'b1; d1 = 4'b0110; settle();
    tick(); d1 = 4'b1001; settle();
    chk1("b2b_c1", 6'b011010);
    tick(); settle(); chk1("b2b_c2", 6'b110010);
    tick(); settle(); chk1("b2b_c3", 6'b110010);
    tick(); settle(); chk1("b2b_c4_ready", 6'b010111);
    tick(); lv1 = 1'b0; settle(); chk1("b2b_c5_first", 6'b111010);
    tick(); settle(); chk1("b2b_c6", 6'b010010);
    tick(); settle(); chk1("b2b_c7", 6'b010010);
    tick(); settle(); chk1("b2b_c8", 6'b110111);
    tick(); settle(); chk1("b2b_idle", 6'b000001);

    // LSB-first 0011 -> 1,1,0,0; MSB instance stays idle with shift_en high.
    lv2 = 1'b1; d2 = 4'b0011; settle();
    tick(); lv2 = 1'b0; settle();
    chk2("lsb_c1", 6'b111010);
    tick(); settle(); chk2("lsb_c2", 6'b110010);
    chk1("idle_ignores_shift", 6'b000001);
    tick(); settle(); chk2("lsb_c3", 6'b010010);
    tick(); settle(); chk2("lsb_c4", 6'b010111);
    tick(); settle(); chk2("lsb_idle", 6'b000001);

    // Reset mid-frame during bit 2 of 1111, then a clean 0001 frame.
    lv1 = 1'b1; d1 = 4'b1111; settle();
    tick(); lv1 = 1'b0; settle();
    chk1("rst_c1", 6'b111010);
    tick(); reset = 1'b1; settle(); chk1("rst_c2", 6'b110010);
    tick(); reset = 1'b0; settle(); chk1("rst_after", 6'b000001);
    lv1 = 1'b1; d1 = 4'b0001; settle();
    tick(); lv1 = 1'b0; settle();
    chk1("post_rst_c1", 6'b011010);
    tick(); settle(); chk1("post_rst_c2", 6'b010010);
    tick(); settle(); chk1("post_rst_c3", 6'b010010);
    tick(); settle(); chk1("post_rst_c4", 6'b110111);
    tick(); settle(); chk1("post_rst_idle", 6'b000001);

    // Busy-ignore: load 1100, then pulse load_valid with new data mid-frame.
    lv1 = 1'b1; d1 = 4'b1100; settle();
    tick(); d1 = 4'b0011; settle();
    chk1("busy_c1", 6'b111010);
    tick(); lv1 = 1'b0; settle(); chk1("busy_c2", 6'b110010);
    tick(); settle(); chk1("busy_c3", 6'b010010);
    tick(); settle(); chk1("busy_c4", 6'b010111);
    tick(); settle(); chk1("busy_no_extra", 6'b000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
